// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the divider FSM state encoding, the default parameter values and
// the function that sizes the divide cycle counter.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

  localparam int DIV_CYCLES_DEFAULT = 32;
  localparam int REGW_DEFAULT       = 5;

  // Counter width is ceil(log2(n)); never narrower than one bit so a
  // two-cycle divide still gets a legal counter.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the datapath and pipe_hazard_ctrl.
// Datapath side (master) drives the hazard sources and receives the
// per-stage stall/flush controls; the controller (slave) does the reverse.
//   Rs1D, Rs2D, RdE   register specifiers for the D and E instructions
//   MemReadE          load in E
//   DivStartE         divide/remainder in E
//   BPredWrongE       branch in E mispredicted
//   TrapM             trap taken in M
//   StallMemM         data memory not ready
//   Stall{F,D,E,M}    hold a stage register
//   Flush{D,E,M,W}    clear a stage register to a bubble
//   DivBusyE/DivDoneE divider status
interface pipe_hazard_ctrl_if #(
  parameter int REGW = hazard_pkg::REGW_DEFAULT
);
  logic [REGW-1:0] Rs1D;
  logic [REGW-1:0] Rs2D;
  logic [REGW-1:0] RdE;
  logic            MemReadE;
  logic            DivStartE;
  logic            BPredWrongE;
  logic            TrapM;
  logic            StallMemM;
  logic            StallF;
  logic            StallD;
  logic            StallE;
  logic            StallM;
  logic            FlushD;
  logic            FlushE;
  logic            FlushM;
  logic            FlushW;
  logic            DivBusyE;
  logic            DivDoneE;

  modport master (
    output Rs1D, Rs2D, RdE, MemReadE, DivStartE, BPredWrongE, TrapM, StallMemM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
    input  DivBusyE, DivDoneE
  );

  modport slave (
    input  Rs1D, Rs2D, RdE, MemReadE, DivStartE, BPredWrongE, TrapM, StallMemM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
    output DivBusyE, DivDoneE
  );
endinterface

// File: rtl/div_seq.sv
// Multicycle divide sequencer: IDLE -> BUSY (DIV_CYCLES-1 cycles) -> DONE
// (one cycle) -> IDLE. Memory stalls freeze progress; a trap abandons the
// divide immediately.
//   clk, reset  clock and synchronous active-high reset
//   start       divide present in E
//   hold        data memory stall, freezes the sequence
//   cancel      trap in M, returns to IDLE next cycle
//   busy        FSM in BUSY
//   done        FSM in DONE (result valid this cycle)
module div_seq
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic hold,
  input  logic cancel,
  output logic busy,
  output logic done
);

  localparam int             CNT_W    = cnt_width(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

  div_state_t       state;
  div_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // State and counter registers; reset abandons any divide in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. The counter is loaded with DIV_CYCLES-2 because the
  // BUSY visit that sees cnt==0 is itself one of the DIV_CYCLES-1 BUSY cycles.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (start && !cancel) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cancel) begin
          state_next = IDLE;
        end else if (!hold) begin
          if (cnt == '0) begin
            state_next = DONE;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
      end
      DONE: begin
        if (cancel || !hold) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Status is masked while reset is high, since the state register only
  // clears on the following edge.
  assign busy = !reset && (state == BUSY);
  assign done = !reset && (state == DONE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: produces per-stage stall (enable) and flush
// (synchronous clear) controls for the F/D/E/M/W pipeline registers from
// load-use hazards, branch mispredicts, traps, memory stalls and the
// multicycle divider.
//   clk, reset  clock and synchronous active-high reset
//   hz          hazard bundle (slave side), see pipe_hazard_ctrl_if
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int REGW       = REGW_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  logic [REGW-1:0] rs1_d;
  logic [REGW-1:0] rs2_d;
  logic [REGW-1:0] rd_e;
  logic            load_use;
  logic            div_busy;
  logic            div_done;
  logic            stall_f, stall_d, stall_e, stall_m;
  logic            flush_d, flush_e, flush_m, flush_w;

  assign rs1_d = hz.Rs1D;
  assign rs2_d = hz.Rs2D;
  assign rd_e  = hz.RdE;

  div_seq #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_seq (
    .clk   (clk),
    .reset (reset),
    .start (hz.DivStartE),
    .hold  (hz.StallMemM),
    .cancel(hz.TrapM),
    .busy  (div_busy),
    .done  (div_done)
  );

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = hz.MemReadE && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  // Priority mux. Each higher source fully decides the controls, so an
  // else-if chain gives the right result and never asserts stall and flush
  // on the same stage.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.TrapM) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
    end else if (hz.StallMemM) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (div_busy) begin
      // E has not resolved yet, so mispredict and load-use wait.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (hz.BPredWrongE) begin
      // D holds a wrong-path instruction, so its load-use hazard is moot.
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign hz.StallF   = stall_f;
  assign hz.StallD   = stall_d;
  assign hz.StallE   = stall_e;
  assign hz.StallM   = stall_m;
  assign hz.FlushD   = flush_d;
  assign hz.FlushE   = flush_e;
  assign hz.FlushM   = flush_m;
  assign hz.FlushW   = flush_w;
  assign hz.DivBusyE = div_busy;
  assign hz.DivDoneE = div_done;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl. Inputs change just after
// the falling edge and outputs are sampled 1 time unit later. Output vectors
// are packed as {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushM,FlushW,
// DivBusyE,DivDoneE}.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipe_hazard_ctrl_if #(.REGW(5)) hz ();

  pipe_hazard_ctrl #(
    .DIV_CYCLES(32),
    .REGW      (5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  localparam logic [9:0] V_RESET   = 10'b0000_1111_00;
  localparam logic [9:0] V_IDLE    = 10'b0000_0000_00;
  localparam logic [9:0] V_LU      = 10'b1100_0100_00;
  localparam logic [9:0] V_DIVBUSY = 10'b1110_0010_10;
  localparam logic [9:0] V_TRAPDIV = 10'b0000_1110_10;
  localparam logic [9:0] V_TRAP    = 10'b0000_1110_00;
  localparam logic [9:0] V_BPRED   = 10'b0000_1100_00;
  localparam logic [9:0] V_MEMSTL  = 10'b1111_0001_00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [9:0] observed();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
            hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW,
            hz.DivBusyE, hz.DivDoneE};
  endfunction

  // Drive one cycle of inputs just after the falling edge, then let the
  // combinational outputs settle.
  task automatic applyStimulus(input logic mr, input logic dstart,
                               input logic bp, input logic trap,
                               input logic smem, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd);
    @(negedge clk);
    hz.MemReadE    = mr;
    hz.DivStartE   = dstart;
    hz.BPredWrongE = bp;
    hz.TrapM       = trap;
    hz.StallMemM   = smem;
    hz.Rs1D        = rs1;
    hz.Rs2D        = rs2;
    hz.RdE         = rd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] expected);
    logic [9:0] obs;
    obs = observed();
    checks++;
    assert (obs === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expected);
    end
  endtask

  task automatic checkValue(input string tag, input int obs, input int expected);
    checks++;
    assert (obs === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expected);
    end
  endtask

  // Run a divide already started; optionally inject a 3-cycle memory stall
  // starting at busy-cycle index stall_at. Reports BUSY cycles, total cycles
  // (BUSY + DONE) and whether StallE stayed high throughout BUSY.
  task automatic runDivide(input int stall_at, output int busy_cnt,
                           output int total, output int stall_ok);
    logic smem;
    busy_cnt = 0;
    total    = 0;
    stall_ok = 1;
    for (int i = 0; i < 100; i++) begin
      smem = (stall_at >= 0) && (i >= stall_at) && (i < stall_at + 3);
      applyStimulus(0, 0, 0, 0, smem, 0, 0, 0);
      if (hz.DivBusyE) begin
        busy_cnt++;
        if (!hz.StallE) stall_ok = 0;
      end else if (hz.DivDoneE) begin
        total = busy_cnt + 1;
        break;
      end else begin
        break;
      end
    end
  endtask

  initial begin
    int busy_cnt;
    int total;
    int stall_ok;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    hz.MemReadE = 0; hz.DivStartE = 0; hz.BPredWrongE = 0;
    hz.TrapM = 0; hz.StallMemM = 0; hz.Rs1D = 0; hz.Rs2D = 0; hz.RdE = 0;

    // Reset held two cycles, including with a hazard present.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_c1", V_RESET);
    applyStimulus(1, 0, 1, 0, 0, 0, 7, 7);
    checkOutput("reset_c2_hazard_masked", V_RESET);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_after_reset", V_IDLE);

    // Load-use on Rs2, then on Rs1; RdE==0 never hazards.
    applyStimulus(1, 0, 0, 0, 0, 3, 7, 7);
    checkOutput("lu_rs2", V_LU);
    applyStimulus(1, 0, 0, 0, 0, 9, 4, 9);
    checkOutput("lu_rs1", V_LU);
    applyStimulus(1, 0, 0, 0, 0, 0, 5, 0);
    checkOutput("lu_rd0", V_IDLE);
    applyStimulus(0, 0, 0, 0, 0, 7, 7, 7);
    checkOutput("no_load_no_lu", V_IDLE);
    applyStimulus(1, 0, 0, 0, 0, 6, 8, 7);
    checkOutput("lu_no_match", V_IDLE);

    // Mispredict overrides a simultaneous load-use.
    applyStimulus(1, 0, 1, 0, 0, 7, 2, 7);
    checkOutput("bpred_over_lu", V_BPRED);

    // Memory stall overrides mispredict, which fires once released.
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 0);
    checkOutput("memstall_over_bpred", V_MEMSTL);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("bpred_after_memstall", V_BPRED);

    // Trap outranks memory stall.
    applyStimulus(1, 0, 1, 1, 1, 7, 7, 7);
    checkOutput("trap_over_all", V_TRAP);

    // Plain divide: 31 BUSY + 1 DONE.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("div_start_cycle", V_IDLE);
    applyStimulus(1, 0, 1, 0, 0, 7, 7, 7);
    checkOutput("div_busy_masks_bpred_lu", V_DIVBUSY);
    runDivide(-1, busy_cnt, total, stall_ok);
    checkValue("div_busy_cycles", busy_cnt + 1, 31);
    checkValue("div_total_cycles", total + 1, 32);
    checkValue("div_stallE_throughout", stall_ok, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("div_after_done", V_IDLE);

    // Divide with a 3-cycle memory stall in the middle: 35 cycles total.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    runDivide(10, busy_cnt, total, stall_ok);
    checkValue("div_memstall_busy", busy_cnt, 34);
    checkValue("div_memstall_total", total, 35);
    checkValue("div_memstall_stallE", stall_ok, 1);

    // Trap while BUSY with cnt==10 (21st BUSY cycle).
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("div_busy_before_trap", V_DIVBUSY);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("trap_during_div", V_TRAPDIV);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("div_cancelled", V_IDLE);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    runDivide(-1, busy_cnt, total, stall_ok);
    checkValue("div_after_trap_busy", busy_cnt, 31);
    checkValue("div_after_trap_total", total, 32);

    // Reset abandons a divide in flight.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_div", V_RESET);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("div_abandoned_by_reset", V_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Generates the per-stage stall (enable) and flush (synchronous reset) controls for the five-stage pipeline registers (F/D/E/M/W). Each pipeline flop uses en = ~StallX and reset = FlushX.
The block detects load-use hazards, branch mispredicts, traps and data-memory stalls. It also sequences multicycle divides with an internal FSM and counter.
It sits beside the datapath and is the driving end of every pipeline register's enable and reset pins.

Parameters:
DIV_CYCLES, 32, number of cycles a divide occupies the E stage (>=2).
REGW, 5, register-specifier width.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
Rs1D  in  REGW  source register 1 of the instruction in D.
Rs2D  in  REGW  source register 2 of the instruction in D.
RdE  in  REGW  destination register of the instruction in E.
MemReadE  in  1  instruction in E is a load.
DivStartE  in  1  instruction in E is a divide/remainder.
BPredWrongE  in  1  branch in E resolved mispredicted.
TrapM  in  1  trap/exception taken in M.
StallMemM  in  1  data memory not ready.
StallF, StallD, StallE, StallM  out  1 each  hold the stage register.
FlushD, FlushE, FlushM, FlushW  out  1 each  clear the stage register to a bubble.
DivBusyE  out  1  divider FSM in BUSY.
DivDoneE  out  1  divide result valid this cycle.

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous and active-high.
- Outputs are combinational from inputs and state. They carry zero added latency.
- While reset=1: all Flush*=1, all Stall*=0, DivBusyE=0, DivDoneE=0.
- On the reset edge: FSM goes to IDLE and cnt goes to 0. A divide in flight is abandoned.
- Divider FSM (div_state_t IDLE, BUSY, DONE); cnt is ceil(log2(DIV_CYCLES)) bits.
  - IDLE: DivStartE & ~TrapM -> BUSY, load cnt = DIV_CYCLES-2.
  - BUSY: StallMemM=1 -> hold cnt. Else cnt==0 -> DONE, else cnt-1.
  - DONE: DivDoneE=1 for one cycle. Next state IDLE, unless StallMemM=1, which holds DONE. DivStartE is ignored in DONE.
  - TrapM=1 in any state -> IDLE next cycle.
  - Result: a divide holds E for exactly DIV_CYCLES cycles (DIV_CYCLES-1 BUSY + 1 DONE) absent memory stalls.
- Load-use hazard: LU = MemReadE & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
- Priority (highest first); each rule sets only the signals it lists, and others take lower-rule values:
  1. TrapM: FlushD=FlushE=FlushM=1, all Stall*=0. FlushW=0.
  2. StallMemM: StallF=StallD=StallE=StallM=1, FlushW=1. Suppress every lower-priority flush.
  3. DivBusyE: StallF=StallD=StallE=1, FlushM=1. BPredWrongE and LU are ignored, since the E instruction has not resolved.
  4. BPredWrongE: FlushD=FlushE=1. LU is ignored, since the D instruction is wrong-path.
  5. LU: StallF=StallD=1, FlushE=1.
- A stage never has Stall and Flush both asserted for the same cycle.
- RdE==0 never creates a hazard.

Decomposition:
- hazard_pkg: div_state_t enum (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), localparam for the cnt width function.
- Sub-module div_seq: divider FSM plus counter. Ports: clk, reset, start, hold (StallMemM), cancel (TrapM), busy, done.
- Top level contains only hazard detection and the priority mux.

Test Plan:
- Reset held 2 cycles -> Flush{D,E,M,W}=1111, Stall*=0. After release with idle inputs, all outputs are 0.
- MemReadE=1, RdE=7, Rs2D=7 -> StallF=StallD=1, FlushE=1. Repeat with RdE=0, Rs1D=0 -> no stall.
- DivStartE=1 for one cycle with DIV_CYCLES=32 -> DivBusyE=1 for 31 cycles, then DivDoneE=1 for 1 cycle; StallE=1 throughout BUSY. Inject StallMemM for 3 cycles mid-divide -> total 35 cycles.
- Divide BUSY with cnt=10 and TrapM=1 -> FlushD/E/M=1 same cycle, Stall*=0, DivBusyE=0 next cycle. A new DivStartE then starts a full 32-cycle divide.
- BPredWrongE=1 with an LU condition simultaneously -> FlushD=FlushE=1, StallD=0.
- StallMemM=1 with BPredWrongE=1 -> Stall F/D/E/M=1, FlushW=1, FlushD=FlushE=0. Release -> mispredict flush then fires.
